mul4b_acc_seq: RTL

//   Sequential accumulator stage directly downstream of the 4x4 combinational multiplier mul4b.

---
 rtl/mul4b_acc_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mul4b_acc_seq.sv
// mul4b_acc_seq: accumulates N_TERMS 8-bit products from mul4b under a
// valid/ready handshake, then holds the sum on a second valid/ready
// handshake until it is taken. Carry out of the accumulator is kept as a
// sticky overflow flag per sum.
module mul4b_acc_seq #(
  parameter  int N_TERMS = 4,
  parameter  int ACC_W   = 10,
  localparam int CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [7:0]       prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             ovf,
  output logic [CNT_W-1:0] term_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic             xfer;
  logic [ACC_W:0]   sum_w;

  assign xfer  = prod_valid & prod_ready;
  assign sum_w = {1'b0, acc_q} + (ACC_W + 1)'(prod);

  // State and datapath registers, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic; clr overrides any transfer or result handshake
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (xfer) state_d = (N_TERMS == 1) ? HOLD : ACCUM;
        end
        ACCUM: begin
          if (xfer && (cnt_q == LAST_CNT)) state_d = HOLD;
        end
        HOLD: begin
          if (acc_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values; acc_valid is registered from the next state so
  // it rises the cycle after the final term and falls with the handshake
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    valid_d = (state_d == HOLD);
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            acc_d = ACC_W'(prod);
            cnt_d = CNT_W'(1);
            ovf_d = 1'b0;
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc_d = sum_w[ACC_W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | sum_w[ACC_W];
          end
        end
        HOLD: begin
          if (acc_ready) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
          end
        end
        default: begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end
      endcase
    end
  end

  // Outputs: prod_ready decodes state only, never prod_valid
  always_comb begin
    prod_ready = (state_q != HOLD);
    acc_valid  = valid_q;
    acc_out    = acc_q;
    ovf        = ovf_q;
    term_cnt   = cnt_q;
  end

endmodule
